// File: rtl/lfsr_hex_if.sv
// Control/observe bundle for the LFSR hex generator.
interface lfsr_hex_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned HEXW = 7 * (WIDTH / 4);

  logic             en;
  logic             mode;
  logic             step;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             blank;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] period;
  logic             wrap;
  logic [HEXW-1:0]  hex;

  modport master (
    output en, mode, step, load, seed, blank,
    input  q, step_cnt, period, wrap, hex
  );

  modport slave (
    input  en, mode, step, load, seed, blank,
    output q, step_cnt, period, wrap, hex
  );
endinterface

// File: rtl/lfsr_hex_gen.sv
// Fibonacci LFSR with free-run/single-step/load modes, period measurement
// and active-low seven-segment readout of the current state.
module lfsr_hex_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h09),
  parameter int unsigned      DIV   = 50_000_000
) (
  input  logic         clk,
  input  logic         clrn,
  lfsr_hex_if.slave    bus
);
  localparam int unsigned NDIG = WIDTH / 4;
  localparam int unsigned HEXW = 7 * NDIG;
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wrap_q, wrap_d;
  logic             step_q, step_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [HEXW-1:0]  hex_q, hex_d;

  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic             presc_hit;
  logic             sh;

  // Nibble to active-low segment code, bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Feedback with forced 1 on the all-zero state so the register never locks up.
  always_comb begin
    fb      = ^(q_q & TAPS);
    if (q_q == '0) fb = 1'b1;
    shifted = {fb, q_q[WIDTH-1:1]};
  end

  // Shift event: prescaler terminal count in free-run, rising step edge in single-step.
  always_comb begin
    presc_hit = (presc_q == PW'(DIV - 1));
    if (bus.mode) sh = bus.en & bus.step & ~step_q;
    else          sh = bus.en & presc_hit;
  end

  // Prescaler held at zero whenever free-run counting is not active.
  always_comb begin
    presc_d = presc_q;
    if (bus.mode || !bus.en || bus.load) presc_d = '0;
    else if (presc_hit)                  presc_d = '0;
    else                                 presc_d = presc_q + PW'(1);
  end

  // Next state for LFSR, counters and wrap flag; load beats shift.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    per_d  = per_q;
    seed_d = seed_q;
    wrap_d = 1'b0;
    step_d = bus.step;
    if (bus.load) begin
      q_d    = bus.seed;
      seed_d = bus.seed;
      cnt_d  = '0;
    end else if (sh) begin
      q_d   = shifted;
      cnt_d = cnt_q + WIDTH'(1);
      if ((shifted == seed_q) && (seed_q != '0)) begin
        wrap_d = 1'b1;
        per_d  = cnt_q + WIDTH'(1);
      end
    end
  end

  // Display decode from the registered state; blank forces all segments off.
  always_comb begin
    hex_d = '0;
    for (int k = 0; k < NDIG; k++) begin
      hex_d[7*k +: 7] = bus.blank ? 7'h7F : seg7(q_q[4*k +: 4]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_q     <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      seed_q  <= '0;
      wrap_q  <= 1'b0;
      step_q  <= 1'b0;
      presc_q <= '0;
      hex_q   <= {NDIG{7'h40}};
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      seed_q  <= seed_d;
      wrap_q  <= wrap_d;
      step_q  <= step_d;
      presc_q <= presc_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.step_cnt = cnt_q;
  assign bus.period   = per_q;
  assign bus.wrap     = wrap_q;
  assign bus.hex      = hex_q;

endmodule

// File: tb/tb_lfsr_hex_gen.sv
// Directed bench for lfsr_hex_gen: 8-bit (TAPS 09) and 4-bit (TAPS 3) instances, DIV=3.
module tb_lfsr_hex_gen;
  logic clk;
  logic clrn;
  int   n_tests;
  int   n_fail;

  lfsr_hex_if #(.WIDTH(8)) b8 ();
  lfsr_hex_if #(.WIDTH(4)) b4 ();

  lfsr_hex_gen #(.WIDTH(8), .TAPS(8'h09), .DIV(3)) dut8 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (b8)
  );

  lfsr_hex_gen #(.WIDTH(4), .TAPS(4'h3), .DIV(3)) dut4 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    tick();
    n_tests++;
    if (b8.q !== 8'h00) begin n_fail++; $display("FAIL reset_q8 got %h want 00", b8.q); end
    n_tests++;
    if (b8.step_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt8 got %h want 00", b8.step_cnt); end
    n_tests++;
    if (b8.period !== 8'h00) begin n_fail++; $display("FAIL reset_period8 got %h want 00", b8.period); end
    n_tests++;
    if (b8.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap8 got %b want 0", b8.wrap); end
    n_tests++;
    if (b8.hex !== {7'h40, 7'h40}) begin n_fail++; $display("FAIL reset_hex8 got %h want 2040", b8.hex); end
    n_tests++;
    if (b4.q !== 4'h0 || b4.hex !== 7'h40) begin
      n_fail++; $display("FAIL reset_dut4 got q=%h hex=%h want q=0 hex=40", b4.q, b4.hex);
    end
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_step8();
    logic [7:0] exp_q [5];
    exp_q = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08};
    b8.mode = 1'b1;
    b8.en   = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      b8.step = 1'b1;
      tick();
      n_tests++;
      if (b8.q !== exp_q[i]) begin n_fail++; $display("FAIL step8_q[%0d] got %h want %h", i, b8.q, exp_q[i]); end
      b8.step = 1'b0;
      tick();
    end
    n_tests++;
    if (b8.step_cnt !== 8'd5) begin n_fail++; $display("FAIL step8_cnt got %0d want 5", b8.step_cnt); end
    n_tests++;
    if (b8.hex !== {7'h40, 7'h00}) begin n_fail++; $display("FAIL step8_hex08 got %h want %h", b8.hex, {7'h40, 7'h00}); end
    b8.step = 1'b1;
    tick();
    n_tests++;
    if (b8.q !== 8'h84) begin n_fail++; $display("FAIL step8_fb got %h want 84", b8.q); end
    b8.step = 1'b0;
    tick();
    n_tests++;
    if (b8.hex !== {7'h00, 7'h19}) begin n_fail++; $display("FAIL step8_hex84 got %h want %h", b8.hex, {7'h00, 7'h19}); end
    n_tests++;
    if (b8.step_cnt !== 8'd6) begin n_fail++; $display("FAIL step8_cnt6 got %0d want 6", b8.step_cnt); end
  endtask

  task automatic test_wrap4();
    logic [3:0] exp_q [15];
    int         pulses;
    exp_q  = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
    pulses = 0;
    b4.mode = 1'b1;
    b4.en   = 1'b1;
    b4.seed = 4'h1;
    b4.load = 1'b1;
    tick();
    b4.load = 1'b0;
    n_tests++;
    if (b4.q !== 4'h1 || b4.step_cnt !== 4'h0) begin
      n_fail++; $display("FAIL wrap4_load got q=%h cnt=%h want q=1 cnt=0", b4.q, b4.step_cnt);
    end
    for (int i = 0; i < 15; i++) begin
      b4.step = 1'b1;
      tick();
      n_tests++;
      if (b4.q !== exp_q[i]) begin n_fail++; $display("FAIL wrap4_q[%0d] got %h want %h", i, b4.q, exp_q[i]); end
      n_tests++;
      if (b4.wrap !== (i == 14)) begin n_fail++; $display("FAIL wrap4_wrap[%0d] got %b want %b", i, b4.wrap, (i == 14)); end
      if (b4.wrap === 1'b1) pulses++;
      b4.step = 1'b0;
      tick();
      if (b4.wrap === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 1) begin n_fail++; $display("FAIL wrap4_pulses got %0d want 1", pulses); end
    n_tests++;
    if (b4.period !== 4'd15) begin n_fail++; $display("FAIL wrap4_period got %0d want 15", b4.period); end
    n_tests++;
    if (b4.step_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap4_cnt got %0d want 15", b4.step_cnt); end
  endtask

  task automatic test_freerun();
    logic [7:0] exp_q [6];
    exp_q = '{8'h84, 8'h84, 8'h42, 8'h42, 8'h42, 8'h21};
    b8.mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (b8.q !== exp_q[i]) begin n_fail++; $display("FAIL free_q[%0d] got %h want %h", i, b8.q, exp_q[i]); end
    end
    b8.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (b8.q !== 8'h21 || b8.step_cnt !== 8'd8) begin
        n_fail++; $display("FAIL free_hold[%0d] got q=%h cnt=%0d want q=21 cnt=8", i, b8.q, b8.step_cnt);
      end
    end
    b8.en = 1'b1;
    tick();
    tick();
    n_tests++;
    if (b8.q !== 8'h21) begin n_fail++; $display("FAIL free_resume_early got %h want 21", b8.q); end
    tick();
    n_tests++;
    if (b8.q !== 8'h90) begin n_fail++; $display("FAIL free_resume got %h want 90", b8.q); end
    tick();
    tick();
    b8.seed = 8'h5A;
    b8.load = 1'b1;
    tick();
    b8.load = 1'b0;
    n_tests++;
    if (b8.q !== 8'h5A || b8.step_cnt !== 8'd0) begin
      n_fail++; $display("FAIL free_load got q=%h cnt=%0d want q=5a cnt=0", b8.q, b8.step_cnt);
    end
    tick();
    tick();
    tick();
    n_tests++;
    if (b8.q !== 8'hAD || b8.step_cnt !== 8'd1) begin
      n_fail++; $display("FAIL free_after_load got q=%h cnt=%0d want q=ad cnt=1", b8.q, b8.step_cnt);
    end
  endtask

  task automatic test_seed0_blank();
    b8.mode = 1'b1;
    b8.seed = 8'h00;
    b8.load = 1'b1;
    tick();
    b8.load = 1'b0;
    n_tests++;
    if (b8.q !== 8'h00) begin n_fail++; $display("FAIL seed0_load got %h want 00", b8.q); end
    b8.step = 1'b1;
    tick();
    n_tests++;
    if (b8.q !== 8'h80 || b8.wrap !== 1'b0) begin
      n_fail++; $display("FAIL seed0_step got q=%h wrap=%b want q=80 wrap=0", b8.q, b8.wrap);
    end
    b8.step = 1'b0;
    tick();
    b8.blank = 1'b1;
    tick();
    n_tests++;
    if (b8.hex !== {7'h7F, 7'h7F}) begin n_fail++; $display("FAIL blank_hex got %h want %h", b8.hex, {7'h7F, 7'h7F}); end
    b8.blank = 1'b0;
    tick();
    n_tests++;
    if (b8.hex !== {7'h00, 7'h40}) begin n_fail++; $display("FAIL unblank_hex got %h want %h", b8.hex, {7'h00, 7'h40}); end
  endtask

  task automatic test_reset_mid();
    b8.mode = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    @(posedge clk);
    #3;
    clrn = 1'b0;
    #1;
    n_tests++;
    if (b8.q !== 8'h00 || b8.step_cnt !== 8'h00 || b8.period !== 8'h00 || b8.wrap !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got q=%h cnt=%h per=%h wrap=%b want all 0",
                         b8.q, b8.step_cnt, b8.period, b8.wrap);
    end
    n_tests++;
    if (b4.period !== 4'h0) begin n_fail++; $display("FAIL rstmid_period4 got %h want 0", b4.period); end
    tick();
    n_tests++;
    if (b8.hex !== {7'h40, 7'h40}) begin n_fail++; $display("FAIL rstmid_hex got %h want 2040", b8.hex); end
    clrn   = 1'b1;
    b8.mode = 1'b1;
    tick();
    b8.step = 1'b1;
    tick();
    n_tests++;
    if (b8.q !== 8'h80) begin n_fail++; $display("FAIL rstmid_first_shift got %h want 80", b8.q); end
    b8.step = 1'b0;
    tick();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    clrn     = 1'b0;
    b8.en    = 1'b0;
    b8.mode  = 1'b1;
    b8.step  = 1'b0;
    b8.load  = 1'b0;
    b8.seed  = 8'h00;
    b8.blank = 1'b0;
    b4.en    = 1'b0;
    b4.mode  = 1'b1;
    b4.step  = 1'b0;
    b4.load  = 1'b0;
    b4.seed  = 4'h0;
    b4.blank = 1'b0;
    test_reset();
    test_step8();
    test_wrap4();
    test_freerun();
    test_seed0_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
